pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 4-bit-opcode RISC core: sits beside the decode-stage control unit.
//  Watches ID/EX state and produces PC stall, IF/ID stall/flush and ID/EX bubble controls.
//  Resolves load-use hazards, taken-branch flushes (B from EX) and IN-port waits.
//  One FSM: RUN, LOAD_STALL, FLUSH, WAIT_IN.
// PARAMETERS
//  REG_AW          2   register-address width
//  LU_STALL_CYCLES 1   load-use stall length in cycles (1..3); the detect cycle counts as cycle 1
//  FLUSH_CYCLES    2   cycles if_id_flush is held after a taken branch (1..3); the detect cycle counts
// PORTS
//  clk            in   1       core clock; all state changes on the rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  id_opcode      in   4       opcode of the instruction in ID
//  id_src1        in   REG_AW  ID source-1 register address
//  id_src2        in   REG_AW  ID source-2 register address
//  id_use1        in   1       ID reads src1 (decode SRC1)
//  id_use2        in   1       ID reads src2 (decode SRC2)
//  ex_mem_r_en    in   1       instruction in EX is a load (opcode 1101)
//  ex_dest        in   REG_AW  EX destination register
//  ex_br_taken    in   1       branch resolved taken in EX
//  in_valid       in   1       external input-port data valid
//  pc_stall       out  1       hold PC
//  if_id_stall    out  1       hold the IF/ID register
//  if_id_flush    out  1       clear IF/ID to NOP (0000)
//  id_ex_bubble   out  1       load NOP into ID/EX
//  in_ack         out  1       one-cycle pulse: ID IN instruction consumed in_valid data
//  state          out  2       RUN=0, LOAD_STALL=1, FLUSH=2, WAIT_IN=3
//  stall_cycles   out  16      perf counter (see CONFIGURATION)
// BEHAVIOUR
//  - Outputs are combinational (Mealy) from state, counter and inputs; state and counter are registered.
//  - Reset (async, any time, including mid-stall): state=RUN, counter=0, stall_cycles=0.
//    While rst_n=0, all outputs are 0.
//  - lu_hit = ex_mem_r_en & ((id_use1 & id_src1==ex_dest) | (id_use2 & id_src2==ex_dest)).
//  - in_wait = (id_opcode==4'b0111) & ~in_valid.
//  - Priority in every state: ex_br_taken > lu_hit > in_wait.
//  - RUN:
//    - ex_br_taken: if_id_flush=1, id_ex_bubble=1, pc_stall=0.
//      Go to FLUSH with cnt=FLUSH_CYCLES-1; if FLUSH_CYCLES=1, stay in RUN.
//    - lu_hit: pc_stall=if_id_stall=id_ex_bubble=1.
//      Go to LOAD_STALL with cnt=LU_STALL_CYCLES-1; if LU_STALL_CYCLES=1, stay in RUN.
//    - in_wait: pc_stall=if_id_stall=id_ex_bubble=1; go to WAIT_IN.
//    - ID opcode 0111 with in_valid=1: in_ack=1; no stall.
//  - LOAD_STALL: pc_stall=if_id_stall=id_ex_bubble=1; cnt decrements each cycle.
//    At cnt==1, return to RUN.
//  - FLUSH: if_id_flush=1, pc_stall=0; cnt decrements; at cnt==1, return to RUN.
//  - WAIT_IN: stall as in_wait. On in_valid=1: in_ack=1, no stall that cycle, return to RUN.
//  - ex_br_taken in LOAD_STALL or WAIT_IN aborts the stall: flush as in RUN, go to FLUSH.
//    No in_ack is issued.
//  - Flush dominates stall: pc_stall and if_id_stall are never 1 in a cycle where if_id_flush=1.
//  - lu_hit and in_wait together: load-use is served first; in_wait is re-evaluated on return to RUN.
//  - in_ack is never asserted in two consecutive cycles for the same instruction.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//    - stall_cycles increments on each cycle with pc_stall=1.
//    - Saturates at 16'hFFFF; cleared only by reset.
//  HAZARD_PERF_CNT_EN undefined: stall_cycles tied to 16'h0000; no counter flops.
// TESTING
//  1. Reset: rst_n=0 mid-WAIT_IN -> all outputs 0, state=0 immediately.
//     After release, in RUN with no hazard -> outputs 0.
//  2. Load-use: ex_mem_r_en=1, ex_dest=2, id_use1=1, id_src1=2, LU_STALL_CYCLES=1
//     -> exactly 1 cycle of pc_stall/if_id_stall/id_ex_bubble, then state=RUN.
//     Repeat with id_use1=0 -> no stall.
//  3. Branch: ex_br_taken=1, FLUSH_CYCLES=2 -> if_id_flush=1 for 2 cycles,
//     id_ex_bubble=1 in the first cycle only, pc_stall=0 throughout.
//  4. IN wait: id_opcode=0111, in_valid=0 for 3 cycles then 1 -> 3 stall cycles,
//     in_ack=1 in the 4th cycle, state=RUN after.
//  5. Abort: in WAIT_IN, assert ex_br_taken -> flush, state=FLUSH, in_ack stays 0.
//     lu_hit together with ex_br_taken -> flush wins, pc_stall=0.
//  6. With HAZARD_PERF_CNT_EN: after tests 2+4, stall_cycles=4.
//     Force 70000 stall cycles -> counter holds 16'hFFFF. Without the macro -> always 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the decode-stage hazard controller and the core pipeline.
// master drives the pipeline status; slave (the controller) drives the stall/flush controls.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 2
);
    logic [3:0]        id_opcode;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_use1;
    logic              id_use2;
    logic              ex_mem_r_en;
    logic [REG_AW-1:0] ex_dest;
    logic              ex_br_taken;
    logic              in_valid;
    logic              pc_stall;
    logic              if_id_stall;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              in_ack;
    logic [1:0]        state;
    logic [15:0]       stall_cycles;

    modport master (
        output id_opcode, id_src1, id_src2, id_use1, id_use2,
        output ex_mem_r_en, ex_dest, ex_br_taken, in_valid,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, in_ack, state, stall_cycles
    );

    modport slave (
        input  id_opcode, id_src1, id_src2, id_use1, id_use2,
        input  ex_mem_r_en, ex_dest, ex_br_taken, in_valid,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, in_ack, state, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, taken-branch flushes and IN-port waits.
// Define HAZARD_PERF_CNT_EN to build the saturating stall-cycle perf counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_AW          = 2,
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  bus
);
    localparam logic [1:0] StRun       = 2'd0;
    localparam logic [1:0] StLoadStall = 2'd1;
    localparam logic [1:0] StFlush     = 2'd2;
    localparam logic [1:0] StWaitIn    = 2'd3;

    localparam logic [1:0] LuInit    = 2'(LU_STALL_CYCLES - 1);
    localparam logic [1:0] FlushInit = 2'(FLUSH_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic [REG_AW-1:0] src1, src2, dest;
    logic lu_hit, in_op, in_wait;
    logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_bubble_c, in_ack_c;

    assign src1    = bus.id_src1;
    assign src2    = bus.id_src2;
    assign dest    = bus.ex_dest;
    assign lu_hit  = bus.ex_mem_r_en & ((bus.id_use1 & (src1 == dest)) |
                                        (bus.id_use2 & (src2 == dest)));
    assign in_op   = (bus.id_opcode == 4'b0111);
    assign in_wait = in_op & ~bus.in_valid;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pc_stall_c      = 1'b0;
        if_id_stall_c   = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_bubble_c  = 1'b0;
        in_ack_c        = 1'b0;
        // A taken branch wins in every state, aborting any stall in progress.
        if (bus.ex_br_taken) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
            state_d        = (FLUSH_CYCLES > 1) ? StFlush : StRun;
            cnt_d          = (FLUSH_CYCLES > 1) ? FlushInit : 2'd0;
        end else begin
            unique case (state_q)
                StLoadStall: begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    id_ex_bubble_c = 1'b1;
                    cnt_d          = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_d = StRun;
                end
                StFlush: begin
                    if_id_flush_c = 1'b1;
                    cnt_d         = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_d = StRun;
                end
                default: begin
                    // RUN and WAIT_IN share the same hazard resolution; WAIT_IN just
                    // remembers that the IN instruction is still parked in ID.
                    if (lu_hit) begin
                        pc_stall_c     = 1'b1;
                        if_id_stall_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        state_d        = (LU_STALL_CYCLES > 1) ? StLoadStall : StRun;
                        cnt_d          = (LU_STALL_CYCLES > 1) ? LuInit : 2'd0;
                    end else if (in_wait || (state_q == StWaitIn && !bus.in_valid)) begin
                        pc_stall_c     = 1'b1;
                        if_id_stall_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        state_d        = StWaitIn;
                    end else begin
                        in_ack_c = (in_op || state_q == StWaitIn) && bus.in_valid;
                        state_d  = StRun;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc_stall     = rst_n & pc_stall_c;
    assign bus.if_id_stall  = rst_n & if_id_stall_c;
    assign bus.if_id_flush  = rst_n & if_id_flush_c;
    assign bus.id_ex_bubble = rst_n & id_ex_bubble_c;
    assign bus.in_ack       = rst_n & in_ack_c;
    assign bus.state        = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 16'h0000;
        end else if (pc_stall_c && stall_cycles_q != 16'hFFFF) begin
            stall_cycles_q <= stall_cycles_q + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
`else
    assign bus.stall_cycles = 16'h0000;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with default parameters (LU=1, FLUSH=2).
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pipeline_hazard_ctrl_if #(.REG_AW(2)) bus ();

    pipeline_hazard_ctrl #(
        .REG_AW(2),
        .LU_STALL_CYCLES(1),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, in_ack}
    logic [4:0] outs;
    assign outs = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_bubble, bus.in_ack};

    localparam logic [4:0] O_NONE  = 5'b00000;
    localparam logic [4:0] O_STALL = 5'b11010;
    localparam logic [4:0] O_BR    = 5'b00110;
    localparam logic [4:0] O_FLUSH = 5'b00100;
    localparam logic [4:0] O_ACK   = 5'b00001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cyc(input string tag, input logic [4:0] exp_outs, input logic [1:0] exp_st);
        chk({tag, ".outs"}, 32'(outs), 32'(exp_outs));
        chk({tag, ".state"}, 32'(bus.state), 32'(exp_st));
    endtask

    task automatic clear_inputs();
        bus.id_opcode   = 4'b0000;
        bus.id_src1     = 2'd0;
        bus.id_src2     = 2'd0;
        bus.id_use1     = 1'b0;
        bus.id_use2     = 1'b0;
        bus.ex_mem_r_en = 1'b0;
        bus.ex_dest     = 2'd0;
        bus.ex_br_taken = 1'b0;
        bus.in_valid    = 1'b0;
    endtask

    // Inputs change just after the falling edge; outputs sampled 2 ns later.
    task automatic next();
        @(negedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);

        // 1. Reset mid-WAIT_IN
        rst_n = 1'b1;
        bus.id_opcode = 4'b0111;
        #2 chk_cyc("rst_enter_wait", O_STALL, 2'd0);
        next();
        #1 chk_cyc("rst_in_wait", O_STALL, 2'd3);
        rst_n = 1'b0;
        #1 chk_cyc("rst_async", O_NONE, 2'd0);
        chk("rst_cnt", 32'(bus.stall_cycles), 32'd0);
        next();
        clear_inputs();
        rst_n = 1'b1;
        #1 chk_cyc("run_idle", O_NONE, 2'd0);
        next();
        #1 chk_cyc("run_idle2", O_NONE, 2'd0);

        // 2. Load-use, one stall cycle
        bus.ex_mem_r_en = 1'b1;
        bus.ex_dest     = 2'd2;
        bus.id_use1     = 1'b1;
        bus.id_src1     = 2'd2;
        #1 chk_cyc("lu_hit", O_STALL, 2'd0);
        next();
        clear_inputs();
        #1 chk_cyc("lu_after", O_NONE, 2'd0);
        next();
        bus.ex_mem_r_en = 1'b1;
        bus.ex_dest     = 2'd2;
        bus.id_use1     = 1'b0;
        bus.id_src1     = 2'd2;
        #1 chk_cyc("lu_nouse", O_NONE, 2'd0);
        bus.id_use2 = 1'b1;
        bus.id_src2 = 2'd2;
        #1 chk_cyc("lu_src2", O_STALL, 2'd0);
        bus.id_src2 = 2'd1;
        #1 chk_cyc("lu_src2_miss", O_NONE, 2'd0);
        next();
        clear_inputs();

        // 3. Taken branch, two flush cycles
        bus.ex_br_taken = 1'b1;
        #1 chk_cyc("br_detect", O_BR, 2'd0);
        next();
        clear_inputs();
        #1 chk_cyc("br_flush2", O_FLUSH, 2'd2);
        next();
        #1 chk_cyc("br_done", O_NONE, 2'd0);

        // 4. IN wait: 3 stall cycles then ack
        bus.id_opcode = 4'b0111;
        #1 chk_cyc("in_w1", O_STALL, 2'd0);
        next();
        #1 chk_cyc("in_w2", O_STALL, 2'd3);
        next();
        #1 chk_cyc("in_w3", O_STALL, 2'd3);
        next();
        bus.in_valid = 1'b1;
        #1 chk_cyc("in_ack", O_ACK, 2'd3);
        next();
        clear_inputs();
        #1 chk_cyc("in_done", O_NONE, 2'd0);

`ifdef HAZARD_PERF_CNT_EN
        chk("perf_after_2_4", 32'(bus.stall_cycles), 32'd4);
`else
        chk("perf_off", 32'(bus.stall_cycles), 32'd0);
`endif

        // 5. Branch aborts WAIT_IN; branch beats load-use
        bus.id_opcode = 4'b0111;
        next();
        bus.ex_br_taken = 1'b1;
        #1 chk_cyc("abort_in_wait", O_BR, 2'd3);
        next();
        clear_inputs();
        #1 chk_cyc("abort_flush", O_FLUSH, 2'd2);
        next();
        #1 chk_cyc("abort_done", O_NONE, 2'd0);
        bus.ex_br_taken = 1'b1;
        bus.ex_mem_r_en = 1'b1;
        bus.ex_dest     = 2'd1;
        bus.id_use1     = 1'b1;
        bus.id_src1     = 2'd1;
        #1 chk_cyc("br_over_lu", O_BR, 2'd0);
        next();
        clear_inputs();
        #1 chk_cyc("br_over_lu_flush", O_FLUSH, 2'd2);
        next();
        #1 chk_cyc("br_over_lu_done", O_NONE, 2'd0);

        // Load-use together with IN wait: load-use first, IN wait afterwards
        bus.id_opcode   = 4'b0111;
        bus.ex_mem_r_en = 1'b1;
        bus.ex_dest     = 2'd3;
        bus.id_use1     = 1'b1;
        bus.id_src1     = 2'd3;
        #1 chk_cyc("lu_in_both", O_STALL, 2'd0);
        next();
        bus.ex_mem_r_en = 1'b0;
        bus.id_use1     = 1'b0;
        #1 chk_cyc("lu_in_then_wait", O_STALL, 2'd0);
        next();
        bus.in_valid = 1'b1;
        #1 chk_cyc("lu_in_ack", O_ACK, 2'd3);
        next();
        clear_inputs();
        #1 chk_cyc("lu_in_done", O_NONE, 2'd0);

        // 6. Saturation: hold an IN wait for 70000 cycles
        bus.id_opcode = 4'b0111;
        repeat (70000) @(negedge clk);
        #1;
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_sat", 32'(bus.stall_cycles), 32'hFFFF);
`else
        chk("perf_sat_off", 32'(bus.stall_cycles), 32'd0);
`endif
        chk_cyc("long_wait", O_STALL, 2'd3);
        next();
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
